pong_match_ctrl: RTL and testbench
==================================

// Module: pong_match_ctrl
// PURPOSE
//   Match sequencer for the VGA pong game. Gates ball motion in the game datapath,
//   requests ball re-centre, keeps per-player scores and drives two 7-seg digits.
//   Sits between the board keys, the frame-rate tick from the VGA timing block and
//   the ball/paddle datapath, which reports goals back to it.
// PARAMETERS
//   WIN_SCORE       5   points needed to win a match (legal range 1..9)
//   PAUSE_FRAMES    60  frames held in POINT_PAUSE after a goal (legal range 1..255)
//   DEBOUNCE_FRAMES 3   consecutive frame ticks with key low before a press is accepted (1..15)
// PORTS
//   clk          in   1  system/pixel clock
//   rst_n        in   1  synchronous reset, active low
//   frame_tick   in   1  one-cycle pulse per video frame
//   key_serve_n  in   1  serve/restart button, active low, asynchronous to clk
//   goal_left    in   1  one-cycle pulse: ball passed the left edge (right player scores)
//   goal_right   in   1  one-cycle pulse: ball passed the right edge (left player scores)
//   ball_run     out  1  high = datapath may move the ball
//   ball_reset   out  1  one-cycle pulse: datapath re-centres the ball
//   serve_dir    out  1  initial ball direction after re-centre (0 = left, 1 = right)
//   score_l      out  4  left player score, binary 0..9
//   score_r      out  4  right player score, binary 0..9
//   hex_l        out  7  7-seg code of score_l, active-low segments {g..a}
//   hex_r        out  7  7-seg code of score_r, active-low segments {g..a}
//   game_over    out  1  high while in GAME_OVER
//   state        out  3  current FSM state encoding (debug)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE, ball_run=0, ball_reset=0, serve_dir=0,
//     scores=0, hex_l=hex_r=7'b1000000, game_over=0, pause/debounce counters=0.
//     Reset mid-match aborts at once; no pending pulse survives.
//   Key path: 2-FF synchroniser on key_serve_n; debounce counter increments on
//     frame_tick while synced key is low, clears when synced key is high; saturates
//     at DEBOUNCE_FRAMES. press = one-cycle pulse on the cycle the counter reaches it.
//     Holding the key produces exactly one press.
//   States: IDLE=0, SERVE=1, PLAY=2, POINT_PAUSE=3, GAME_OVER=4.
//     IDLE: on press -> SERVE, scores cleared, ball_reset pulsed.
//     SERVE: ball_run=0; on press -> PLAY.
//     PLAY: ball_run=1. goal_right alone -> score_l+1; goal_left alone -> score_r+1.
//       Both in same cycle -> no score change, treated as replay.
//       Any goal -> POINT_PAUSE, ball_run=0 next cycle, ball_reset pulsed on entry,
//       serve_dir set toward the conceding player's side (goal_right -> 1, goal_left -> 0);
//       replay keeps serve_dir.
//       If updated score == WIN_SCORE -> GAME_OVER instead (ball_reset still pulsed).
//     POINT_PAUSE: counter counts frame_ticks; after PAUSE_FRAMES ticks -> SERVE.
//     GAME_OVER: game_over=1, scores frozen; on press -> IDLE with scores kept until
//       the IDLE->SERVE press clears them.
//   Goal pulses outside PLAY are ignored. A press outside IDLE/SERVE/GAME_OVER is dropped.
//   All outputs registered; latency goal pulse -> score/ball_run/ball_reset = 1 clk;
//     hex_* follow score_* in the same cycle (combinational decode of registered score).
//   Scores never exceed WIN_SCORE (at most 9); no wrap.
// CONFIGURATION
//   PONG_AUTO_SERVE_EN defined: SERVE after POINT_PAUSE goes to PLAY on the next
//     frame_tick without a press; the first serve after IDLE still needs a press.
//   Not defined: every SERVE waits for a debounced press.
// TESTING
//   1 rst_n=0 2 clks, key held low -> state=0, scores 0, hex_l=hex_r=7'b1000000, no pulses.
//   2 key low for 3 frame_ticks -> single ball_reset pulse, state IDLE->SERVE; 2nd press -> PLAY,
//     ball_run=1.
//   3 In PLAY pulse goal_right -> next clk score_l=1, ball_run=0, ball_reset=1 for 1 clk,
//     serve_dir=1; after 60 frame_ticks state=SERVE.
//   4 goal_left and goal_right in same cycle -> scores unchanged, state=POINT_PAUSE.
//   5 Drive score_r to 5 -> game_over=1, state=4; further goals ignored; press -> IDLE.
//   6 With PONG_AUTO_SERVE_EN: after pause, PLAY reached one frame_tick later with key high;
//     without it, state stays SERVE for 200 frames.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for the VGA pong game.
// Gates ball motion, requests ball re-centre, keeps per-player scores and
// drives two 7-segment digits. Serve key is synchronised and debounced on
// the video frame tick.
// Optional feature macro: PONG_AUTO_SERVE_EN -- when defined, a SERVE that
// follows a point pause launches the ball on the next frame tick without a
// key press; the first serve after IDLE always needs a press.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE       = 5,
  parameter int unsigned PAUSE_FRAMES    = 60,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       key_serve_n,
  input  logic       goal_left,
  input  logic       goal_right,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [6:0] hex_l,
  output logic [6:0] hex_r,
  output logic       game_over,
  output logic [2:0] state
);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_SERVE       = 3'd1;
  localparam logic [2:0] ST_PLAY        = 3'd2;
  localparam logic [2:0] ST_POINT_PAUSE = 3'd3;
  localparam logic [2:0] ST_GAME_OVER   = 3'd4;

  localparam logic [3:0] WIN_Q      = 4'(WIN_SCORE);
  localparam logic [3:0] DB_FULL    = 4'(DEBOUNCE_FRAMES);
  localparam logic [3:0] DB_PRE     = 4'(DEBOUNCE_FRAMES - 1);
  localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

  logic       key_meta;
  logic       key_sync;
  logic [3:0] db_cnt;
  logic       press;
  logic [7:0] pause_cnt;
  logic       serve_go;

  logic       gl_only;
  logic       gr_only;
  logic [3:0] score_l_nxt;
  logic [3:0] score_r_nxt;
  logic       win_hit;

  // Two-flop synchroniser for the asynchronous serve key (idle level is high)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_serve_n;
      key_sync <= key_meta;
    end
  end

  // Frame-rate debounce: count ticks while key low, one press pulse on reaching the limit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_sync) begin
        db_cnt <= '0;
      end else if (frame_tick && (db_cnt != DB_FULL)) begin
        db_cnt <= db_cnt + 4'd1;
        press  <= (db_cnt == DB_PRE);
      end
    end
  end

`ifdef PONG_AUTO_SERVE_EN
  logic auto_armed;

  // Arm automatic launch only for a SERVE entered from the point pause
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auto_armed <= 1'b0;
    end else if (state == ST_POINT_PAUSE && frame_tick && pause_cnt == PAUSE_LAST) begin
      auto_armed <= 1'b1;
    end else if (state != ST_SERVE) begin
      auto_armed <= 1'b0;
    end
  end

  // SERVE leaves on a press, or on a frame tick once armed
  always_comb begin
    serve_go = press || (auto_armed && frame_tick);
  end
`else
  // SERVE leaves only on a debounced press
  always_comb begin
    serve_go = press;
  end
`endif

  // Goal decode and next scores; a simultaneous double goal is a replay
  always_comb begin
    gl_only     = goal_left && !goal_right;
    gr_only     = goal_right && !goal_left;
    score_l_nxt = score_l;
    score_r_nxt = score_r;
    if (gr_only && (score_l < WIN_Q)) begin
      score_l_nxt = score_l + 4'd1;
    end
    if (gl_only && (score_r < WIN_Q)) begin
      score_r_nxt = score_r + 4'd1;
    end
    win_hit = (score_l_nxt == WIN_Q) || (score_r_nxt == WIN_Q);
  end

  // Match sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ball_run   <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b0;
      score_l    <= '0;
      score_r    <= '0;
      game_over  <= 1'b0;
      pause_cnt  <= '0;
    end else begin
      ball_reset <= 1'b0;
      case (state)
        ST_IDLE: begin
          ball_run <= 1'b0;
          if (press) begin
            state      <= ST_SERVE;
            score_l    <= '0;
            score_r    <= '0;
            ball_reset <= 1'b1;
          end
        end
        ST_SERVE: begin
          ball_run <= 1'b0;
          if (serve_go) begin
            state    <= ST_PLAY;
            ball_run <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (goal_left || goal_right) begin
            ball_run   <= 1'b0;
            ball_reset <= 1'b1;
            score_l    <= score_l_nxt;
            score_r    <= score_r_nxt;
            pause_cnt  <= '0;
            if (gr_only) begin
              serve_dir <= 1'b1;
            end else if (gl_only) begin
              serve_dir <= 1'b0;
            end
            if (win_hit) begin
              state     <= ST_GAME_OVER;
              game_over <= 1'b1;
            end else begin
              state <= ST_POINT_PAUSE;
            end
          end
        end
        ST_POINT_PAUSE: begin
          ball_run <= 1'b0;
          if (frame_tick) begin
            if (pause_cnt == PAUSE_LAST) begin
              state     <= ST_SERVE;
              pause_cnt <= '0;
            end else begin
              pause_cnt <= pause_cnt + 8'd1;
            end
          end
        end
        ST_GAME_OVER: begin
          ball_run <= 1'b0;
          if (press) begin
            state     <= ST_IDLE;
            game_over <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          ball_run  <= 1'b0;
          game_over <= 1'b0;
          pause_cnt <= '0;
        end
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Digit decode follows the registered scores directly
  always_comb begin
    hex_l = seg7(score_l);
    hex_r = seg7(score_r);
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: a point-level match model queues the
// expected outcome of every ball re-centre; a monitor checks each ball_reset.
module tb_pong_match_ctrl;

  localparam int WIN   = 5;
  localparam int PAUSE = 60;
  localparam int DEB   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       key_serve_n = 1'b0;
  logic       goal_left = 1'b0;
  logic       goal_right = 1'b0;
  logic       ball_run;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [6:0] hex_l;
  logic [6:0] hex_r;
  logic       game_over;
  logic [2:0] state;

  pong_match_ctrl #(
    .WIN_SCORE(WIN),
    .PAUSE_FRAMES(PAUSE),
    .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .key_serve_n(key_serve_n),
    .goal_left(goal_left), .goal_right(goal_right), .ball_run(ball_run),
    .ball_reset(ball_reset), .serve_dir(serve_dir), .score_l(score_l),
    .score_r(score_r), .hex_l(hex_l), .hex_r(hex_r), .game_over(game_over),
    .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int sl;
    int sr;
    int dir;
    int st;
    int go;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;

  // match model: phase numbers are the documented state codes
  int m_sl = 0, m_sr = 0, m_dir = 0, m_phase = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push_exp();
    exp_t e;
    e.sl = m_sl; e.sr = m_sr; e.dir = m_dir; e.st = m_phase;
    e.go = (m_phase == 4) ? 1 : 0;
    expq.push_back(e);
  endfunction

  function automatic void model_press();
    case (m_phase)
      0: begin m_sl = 0; m_sr = 0; m_phase = 1; push_exp(); end
      1: m_phase = 2;
      4: m_phase = 0;
      default: ;
    endcase
  endfunction

  function automatic void model_goal(input int l, input int r);
    if (m_phase != 2 || (l == 0 && r == 0)) return;
    if (r == 1 && l == 0) begin m_sl++; m_dir = 1; end
    else if (l == 1 && r == 0) begin m_sr++; m_dir = 0; end
    m_phase = (m_sl == WIN || m_sr == WIN) ? 4 : 3;
    push_exp();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (3) step();
  endtask

  task automatic press(input int n);
    if (n >= DEB) model_press();
    key_serve_n = 1'b0;
    repeat (4) step();
    repeat (n) frame();
    key_serve_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic goal(input int l, input int r);
    model_goal(l, r);
    goal_left  = (l != 0);
    goal_right = (r != 0);
    step();
    goal_left  = 1'b0;
    goal_right = 1'b0;
    repeat (3) step();
  endtask

  task automatic finish_pause(input bit hold);
    repeat (PAUSE - 1) frame();
    check("pause_hold_state", int'(state), 3);
    frame();
    m_phase = 1;
    check("pause_to_serve", int'(state), 1);
`ifdef PONG_AUTO_SERVE_EN
    frame();
    m_phase = 2;
    check("auto_serve_state", int'(state), 2);
`else
    if (hold) begin
      repeat (200) frame();
      check("serve_waits_key", int'(state), 1);
    end
    press(3);
    check("serve_press_state", int'(state), m_phase);
`endif
    check("run_after_serve", int'(ball_run), 1);
  endtask

  task automatic play_match(input int bias);
    int r;
    int guard;
    guard = 0;
    while (m_phase != 4 && guard < 80) begin
      repeat ($urandom_range(0, 5)) step();
      check("run_in_play", int'(ball_run), 1);
      r = $urandom_range(0, 9);
      if (r == 0) goal(1, 1);
      else if (r <= bias) goal(1, 0);
      else goal(0, 1);
      if (m_phase == 3) finish_pause(1'b0);
      guard++;
    end
  endtask

  // monitor: every ball re-centre must match the next queued model outcome
  always @(negedge clk) begin
    if (rst_n && ball_reset) begin
      if (expq.size() == 0) begin
        check("unexpected_ball_reset", 1, 0);
      end else begin
        mon_e = expq.pop_front();
        check("ev_score_l", int'(score_l), mon_e.sl);
        check("ev_score_r", int'(score_r), mon_e.sr);
        check("ev_serve_dir", int'(serve_dir), mon_e.dir);
        check("ev_state", int'(state), mon_e.st);
        check("ev_game_over", int'(game_over), mon_e.go);
        check("ev_ball_run", int'(ball_run), 0);
        check("ev_hex_l", int'(hex_l), int'(seg_tab[mon_e.sl]));
        check("ev_hex_r", int'(hex_r), int'(seg_tab[mon_e.sr]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with key held low
    rst_n = 1'b0;
    key_serve_n = 1'b0;
    repeat (2) step();
    check("rst_state", int'(state), 0);
    check("rst_score_l", int'(score_l), 0);
    check("rst_score_r", int'(score_r), 0);
    check("rst_hex_l", int'(hex_l), 'b1000000);
    check("rst_hex_r", int'(hex_r), 'b1000000);
    check("rst_ball_reset", int'(ball_reset), 0);
    check("rst_ball_run", int'(ball_run), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_serve_dir", int'(serve_dir), 0);
    rst_n = 1'b1;
    key_serve_n = 1'b1;
    repeat (4) step();

    // one tick short of the debounce limit is not a press
    press(DEB - 1);
    check("short_press_idle", int'(state), 0);

    // long hold gives exactly one press
    press(DEB + 3);
    check("idle_to_serve", int'(state), 1);
    check("serve_ball_run", int'(ball_run), 0);

    // goals outside PLAY are ignored
    goal(0, 1);
    check("serve_goal_ign_l", int'(score_l), 0);
    check("serve_goal_ign_st", int'(state), 1);

    press(3);
    check("serve_to_play", int'(state), 2);
    check("play_ball_run", int'(ball_run), 1);

    // a press in PLAY is dropped
    press(3);
    check("play_press_drop", int'(state), 2);

    goal(0, 1);
    finish_pause(1'b1);
    goal(1, 1);
    check("replay_score_l", int'(score_l), m_sl);
    finish_pause(1'b0);

    play_match(5);
    check("go_state", int'(state), 4);
    check("go_flag", int'(game_over), 1);
    goal(1, 0);
    goal(0, 1);
    check("go_frozen_l", int'(score_l), m_sl);
    check("go_frozen_r", int'(score_r), m_sr);
    press(3);
    check("go_to_idle", int'(state), 0);
    check("idle_kept_l", int'(score_l), m_sl);
    check("idle_kept_r", int'(score_r), m_sr);
    check("idle_go_clear", int'(game_over), 0);

    press(3);
    press(3);
    check("m2_play", int'(state), 2);

    // reset mid-match swallows a coincident goal
    goal_right = 1'b1;
    rst_n = 1'b0;
    step();
    goal_right = 1'b0;
    check("midrst_state", int'(state), 0);
    check("midrst_score_l", int'(score_l), 0);
    check("midrst_ball_reset", int'(ball_reset), 0);
    check("midrst_ball_run", int'(ball_run), 0);
    rst_n = 1'b1;
    m_phase = 0; m_sl = 0; m_sr = 0; m_dir = 0;
    repeat (3) step();
    check("postrst_ball_reset", int'(ball_reset), 0);

    press(3);
    press(3);
    play_match(8);
    check("m3_state", int'(state), 4);
    check("m3_score_r", int'(score_r), m_sr);
    check("m3_score_l", int'(score_l), m_sl);

    repeat (5) step();
    check("pending_events", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
